// File: rtl/riscv_dmem_resp.sv
// Data-memory responder for the RV32I core: lane alignment, word array, fixed wait-state latency.
// Define RISCV_DMEM_MISALIGN_CHK_EN to flag misaligned half/word accesses instead of aligning them down.
module riscv_dmem_resp #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_dmem_req_valid,
  output logic                      o_dmem_req_ready,
  input  logic [31:0]               i_dmem_addr,
  input  logic                      i_dmem_wr_en,
  input  logic [DATA_WIDTH/8-1:0]   i_dmem_byte_sel,
  input  logic [DATA_WIDTH-1:0]     i_dmem_wdata,
  output logic                      o_dmem_rsp_valid,
  output logic [DATA_WIDTH-1:0]     o_dmem_rdata,
  output logic                      o_dmem_err
);

  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned BA_W  = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [BA_W-1:0]       addr;
    logic                  wr_en;
    logic [LANES-1:0]      sel;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                r_state;
  state_t                w_state_nxt;
  req_t                  r_req;
  req_t                  w_req;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ready;
  logic                  r_rsp_valid;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_misalign;
  logic [LANES-1:0]      w_sel;
  logic [LANES-1:0]      w_mask_sh;
  logic [1:0]            w_off_raw;
  logic [1:0]            w_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [DATA_WIDTH-1:0] w_wdata_sh;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_lane_mask;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_addr;

  assign w_unused_addr = ^i_dmem_addr[31:BA_W];
  assign w_accept      = (r_state == S_IDLE) && r_ready && i_dmem_req_valid;
  assign w_commit      = (w_state_nxt == S_RESP);

  // With zero wait states the commit edge is the accept edge, so use the live request then.
  always_comb begin
    w_req = r_req;
    if (r_state == S_IDLE) begin
      w_req.addr  = i_dmem_addr[BA_W-1:0];
      w_req.wr_en = i_dmem_wr_en;
      w_req.sel   = i_dmem_byte_sel;
      w_req.wdata = i_dmem_wdata;
    end
  end

  always_comb begin
    w_sel = w_req.sel;
    if ((w_req.sel != LANES'(1)) && (w_req.sel != LANES'(3))) w_sel = '1;
  end

  assign w_off_raw = w_req.addr[1:0];

`ifdef RISCV_DMEM_MISALIGN_CHK_EN
  assign w_misalign = ((w_sel == LANES'(3)) && w_off_raw[0]) ||
                      ((w_sel == '1) && (w_off_raw != 2'd0));
  assign w_off      = w_off_raw;
`else
  assign w_misalign = 1'b0;
  assign w_off      = (w_sel == '1)        ? 2'd0 :
                      (w_sel == LANES'(3)) ? {w_off_raw[1], 1'b0} : w_off_raw;
`endif

  assign w_mask_sh  = LANES'(w_sel << w_off);
  assign w_wdata_sh = w_req.wdata << {w_off, 3'b000};
  assign w_idx      = w_req.addr[BA_W-1:2];
  assign w_rd_word  = r_mem[w_idx];

  always_comb begin
    w_lane_mask = '0;
    for (int i = 0; i < int'(LANES); i++) w_lane_mask[8*i +: 8] = {8{w_sel[i]}};
  end

  assign w_rdata = (w_rd_word >> {w_off, 3'b000}) & w_lane_mask;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == CNT_W'(WAIT_CYCLES - 1)) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_cnt       <= (r_state == S_WAIT) ? r_cnt + CNT_W'(1) : '0;
      r_ready     <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      if (w_commit) begin
        r_err   <= w_misalign;
        r_rdata <= (w_req.wr_en || w_misalign) ? '0 : w_rdata;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) r_req <= w_req;
  end

  // Array is never reset; a reset in flight suppresses the pending write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_commit && w_req.wr_en && !w_misalign) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (w_mask_sh[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

  assign o_dmem_req_ready = r_ready;
  assign o_dmem_rsp_valid = r_rsp_valid;
  assign o_dmem_rdata     = r_rdata;
  assign o_dmem_err       = r_err;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Bench for riscv_dmem_resp: byte-addressed reference model plus directed literal checks.
module tb_riscv_dmem_resp;

  localparam int WC = 1;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  sel = '0;
  logic        ready;
  logic        rsp_valid;
  logic        err;
  logic [31:0] rdata;

  riscv_dmem_resp #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_dmem_req_valid (valid),
    .o_dmem_req_ready (ready),
    .i_dmem_addr      (addr),
    .i_dmem_wr_en     (we),
    .i_dmem_byte_sel  (sel),
    .i_dmem_wdata     (wdata),
    .o_dmem_rsp_valid (rsp_valid),
    .o_dmem_rdata     (rdata),
    .o_dmem_err       (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Reference model: memory as individual bytes, responses due a fixed time after accept.
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          due;
  } txn_t;

  txn_t        q[$];
  logic [7:0]  mdl_mem [int];
  int          busy_until = -1;
  bit          prev_rst = 1'b1;
  logic [31:0] e_rdata = '0;
  logic        e_err = 1'b0;
  bit          m_exp_ready;
  bit          m_exp_v;

  function automatic void mdl_resp(input txn_t t, output logic [31:0] rd, output logic e);
    int size;
    int off;
    int base;
    case (t.sel)
      4'b0001: size = 1;
      4'b0011: size = 2;
      default: size = 4;
    endcase
    off = int'(t.addr[1:0]);
    rd  = '0;
    e   = 1'b0;
`ifdef RISCV_DMEM_MISALIGN_CHK_EN
    if ((off % size) != 0) begin
      e = 1'b1;
      return;
    end
`else
    off = off - (off % size);
`endif
    base = int'(t.addr[AW+1:2]) * 4 + off;
    for (int k = 0; k < size; k++) begin
      if (t.we) mdl_mem[base + k] = t.wdata[8*k +: 8];
      else      rd[8*k +: 8] = mdl_mem.exists(base + k) ? mdl_mem[base + k] : 8'hxx;
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      e_rdata  = '0;
      e_err    = 1'b0;
      prev_rst = 1'b1;
    end else begin
      m_exp_ready = !prev_rst && (cyc > busy_until);
      m_exp_v     = (q.size() > 0) && (q[0].due == cyc);
      if (m_exp_v) begin
        mdl_resp(q[0], e_rdata, e_err);
        void'(q.pop_front());
      end
      chk("mon_ready", ready, m_exp_ready);
      chk("mon_rsp_valid", rsp_valid, m_exp_v);
      chk("mon_rdata", rdata, e_rdata);
      chk("mon_err", err, e_err);
      if (valid && m_exp_ready) begin
        q.push_back('{addr, we, sel, wdata, cyc + 1 + WC});
        busy_until = cyc + 1 + WC;
      end
      prev_rst = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds valid until accepted; returns just after the accept edge with valid still high.
  task automatic send(input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d, output int acc);
    addr = a; we = w; sel = s; wdata = d; valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout @cyc %0d: got no accept, want accept within 50 cycles", cyc);
    end
    tick(1);
  endtask

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rc = cyc;
        break;
      end
    end
  endtask

  task automatic xact(input string nm, input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d, input logic [31:0] x_rd, input logic x_err);
    int acc;
    int rc;
    send(a, w, s, d, acc);
    valid = 1'b0;
    wait_rsp(rc);
    chk({nm, "_lat"}, rc - acc, WC + 1);
    chk({nm, "_rdata"}, rdata, x_rd);
    chk({nm, "_err"}, err, x_err);
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200us");
    $fatal(1);
  end

  initial begin
    int acc1;
    int acc2;
    int rc;
    int seen;

    // Reset and idle
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", ready, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_err", err, 1'b0);
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    @(negedge clk);
    chk("ready_after_rst", ready, 1'b1);
    tick(5);

    // Preloads and the word store/load pair
    xact("st_20", 32'h20, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0);
    xact("st_00", 32'h00, 1'b1, 4'b1111, 32'h01234567, 32'h0, 1'b0);
    xact("st_04", 32'h04, 1'b1, 4'b1111, 32'h89ABCDEF, 32'h0, 1'b0);
    xact("st_10", 32'h10, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("ld_10", 32'h10, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0);

    // Byte lanes
    xact("stb_13", 32'h13, 1'b1, 4'b0001, 32'h0000005A, 32'h0, 1'b0);
    xact("ldb_13", 32'h13, 1'b0, 4'b0001, 32'h0, 32'h0000005A, 1'b0);
    xact("ldw_10", 32'h10, 1'b0, 4'b1111, 32'h0, 32'h5AADBEEF, 1'b0);
    xact("ldh_12", 32'h12, 1'b0, 4'b0011, 32'h0, 32'h00005AAD, 1'b0);
    xact("ldb_11", 32'h11, 1'b0, 4'b0001, 32'h0, 32'h000000BE, 1'b0);
    xact("sth_14", 32'h14, 1'b1, 4'b0011, 32'hFFFF1234, 32'h0, 1'b0);
    xact("ldh_14", 32'h14, 1'b0, 4'b0011, 32'h0, 32'h00001234, 1'b0);

    // Illegal byte_sel acts as a full word
    xact("st_ill", 32'h08, 1'b1, 4'b0101, 32'hA5A5C3C3, 32'h0, 1'b0);
    xact("ld_ill", 32'h08, 1'b0, 4'b0000, 32'h0, 32'hA5A5C3C3, 1'b0);

    // Back-to-back with valid held high
    send(32'h00, 1'b0, 4'b1111, 32'h0, acc1);
    send(32'h04, 1'b0, 4'b1111, 32'h0, acc2);
    valid = 1'b0;
    chk("b2b_spacing", acc2 - acc1, WC + 2);
    wait_rsp(rc);
    chk("b2b_lat", rc - acc2, WC + 1);
    chk("b2b_rdata", rdata, 32'h89ABCDEF);
    tick(1);

    // Reset during WAIT drops the store and its response
    send(32'h20, 1'b1, 4'b1111, 32'h11111111, acc1);
    valid = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("midrst_no_rsp", seen, 0);
    tick(1);
    xact("ld_20_after_rst", 32'h20, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0);

    // Misaligned accesses
`ifdef RISCV_DMEM_MISALIGN_CHK_EN
    xact("mis_ldw_22", 32'h22, 1'b0, 4'b1111, 32'h0,      32'h0,        1'b1);
    xact("mis_sth_21", 32'h21, 1'b1, 4'b0011, 32'hBBBB,   32'h0,        1'b1);
    xact("mis_ldh_23", 32'h23, 1'b0, 4'b0011, 32'h0,      32'h0,        1'b1);
    xact("ld_20_keep", 32'h20, 1'b0, 4'b1111, 32'h0,      32'hCAFEF00D, 1'b0);
`else
    xact("mis_ldw_22", 32'h22, 1'b0, 4'b1111, 32'h0,      32'hCAFEF00D, 1'b0);
    xact("mis_sth_21", 32'h21, 1'b1, 4'b0011, 32'hBBBB,   32'h0,        1'b0);
    xact("mis_ldh_23", 32'h23, 1'b0, 4'b0011, 32'h0,      32'h0000CAFE, 1'b0);
    xact("ld_20_algn", 32'h20, 1'b0, 4'b1111, 32'h0,      32'hCAFEBBBB, 1'b0);
`endif
    xact("ldb_23", 32'h23, 1'b0, 4'b0001, 32'h0, 32'h000000CA, 1'b0);

    tick(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
